// File: rtl/data_sram_pkg.sv
// Shared types and constants for the data-memory responder and its FIFO.
package data_sram_pkg;

    // Access-size encodings carried on data_sram_size
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    localparam int          RESP_LAT_DEFAULT = 1;
    localparam logic [15:0] STALL_LFSR_SEED  = 16'hACE1;

    // One queued response: write acks carry rdata=0
    typedef struct packed {
        logic        wr;
        logic [31:0] rdata;
    } resp_entry_t;

    // Merge new write data into an old word, one byte lane per strobe bit
    function automatic logic [31:0] strb_merge(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  strb);
        logic [31:0] merged;
        merged = old_w;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) merged[8*b +: 8] = new_w[8*b +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/sram_resp_fifo.sv
// In-order response FIFO, power-of-two depth, with full/empty/count.
module sram_resp_fifo
    import data_sram_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  resp_entry_t              din,
    input  logic                     pop,
    output resp_entry_t              dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    resp_entry_t   store [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign dout    = store[rd_ptr];

    // Entry storage; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (push_ok) store[wr_ptr] <= din;
    end

    // Pointers wrap naturally on the power-of-two depth; count tracks occupancy
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/data_sram_responder.sv
// Responder end of the SRAM-like data-memory interface: word array,
// in-order responses after a programmable latency.
// Optional macro DATA_SRAM_STALL_EN: an LFSR randomly withholds addr_ok.
module data_sram_responder
    import data_sram_pkg::*;
#(
    parameter int ADDR_W   = 10,
    parameter int QDEPTH   = 4,
    parameter int RESP_LAT = RESP_LAT_DEFAULT
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     data_sram_req,
    input  logic                     data_sram_wr,
    input  logic [1:0]               data_sram_size,
    input  logic [3:0]               data_sram_wstrb,
    input  logic [31:0]              data_sram_addr,
    input  logic [31:0]              data_sram_wdata,
    output logic                     data_sram_addr_ok,
    output logic                     data_sram_data_ok,
    output logic [31:0]              data_sram_rdata,
    output logic [$clog2(QDEPTH):0]  outstanding
);

    localparam int         CW   = $clog2(QDEPTH) + 1;
    localparam logic [3:0] LAT4 = 4'(RESP_LAT);

    logic [31:0]       mem [2**ADDR_W];
    logic [ADDR_W-1:0] idx;
    logic              hs;
    logic              stall_ok;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;
    resp_entry_t       push_ent;
    resp_entry_t       head;
    logic [3:0]        cdown;
    logic              unused_bits;

    // Lane selection comes from wstrb alone; size and out-of-range address bits are don't-care
    assign unused_bits = ^{data_sram_size, data_sram_addr[31:ADDR_W+2], data_sram_addr[1:0]};

    assign idx = data_sram_addr[ADDR_W+1:2];

`ifdef DATA_SRAM_STALL_EN
    logic [15:0] lfsr;

    // Fibonacci LFSR (taps 16,14,13,11) advancing every cycle to throttle addr_ok
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) lfsr <= STALL_LFSR_SEED;
        else         lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    assign stall_ok = lfsr[0];
`else
    assign stall_ok = 1'b1;
`endif

    // Gated by resetn so addr_ok is low throughout reset, not just after an edge
    assign data_sram_addr_ok = resetn & ~fifo_full & stall_ok;
    assign hs                = data_sram_req & data_sram_addr_ok;
    assign data_sram_data_ok = ~fifo_empty & (cdown == 4'd0);
    assign data_sram_rdata   = (data_sram_data_ok && !head.wr) ? head.rdata : 32'd0;
    assign outstanding       = fifo_count;

    // Read data is sampled at handshake, before any same-edge write lands
    always_comb begin
        push_ent       = '0;
        push_ent.wr    = data_sram_wr;
        push_ent.rdata = data_sram_wr ? 32'd0 : mem[idx];
    end

    // Word array write with byte strobes; contents survive reset
    always_ff @(posedge clk) begin
        if (hs && data_sram_wr) mem[idx] <= strb_merge(mem[idx], data_sram_wdata, data_sram_wstrb);
    end

    // Head countdown: reload whenever a new entry becomes head, else count down to zero
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cdown <= 4'd0;
        end else if ((hs && fifo_empty) ||
                     (data_sram_data_ok && (fifo_count > CW'(1) || hs))) begin
            cdown <= LAT4;
        end else if (!fifo_empty && cdown != 4'd0) begin
            cdown <= cdown - 4'd1;
        end
    end

    sram_resp_fifo #(
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (hs),
        .din    (push_ent),
        .pop    (data_sram_data_ok),
        .dout   (head),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: two instances (latency 1 and 7) checked
// every cycle against a queue/array model, plus directed literal checks.
module tb_data_sram_responder;
    import data_sram_pkg::*;

    localparam int QD    = 4;
    localparam int LAT_A = 1;
    localparam int LAT_B = 7;

    logic clk;
    logic resetn;

    logic        req   [2];
    logic        wr    [2];
    logic [1:0]  sz    [2];
    logic [3:0]  strb  [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic        aok   [2];
    logic        dok   [2];
    logic [31:0] rd    [2];
    logic [2:0]  outs  [2];

    int cyc    = 0;
    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        int          due;
        logic        wr;
        logic [31:0] data;
        logic        known;
    } ent_t;

    typedef struct {
        int          c;
        logic [31:0] d;
    } rl_t;

    ent_t        mq   [2][$];
    rl_t         rlog [2][$];
    logic [31:0] mmem [2][1024];
    logic [3:0]  mk   [2][1024];

    data_sram_responder #(.ADDR_W(10), .QDEPTH(QD), .RESP_LAT(LAT_A)) u_dut_a (
        .clk (clk), .resetn (resetn),
        .data_sram_req (req[0]), .data_sram_wr (wr[0]), .data_sram_size (sz[0]),
        .data_sram_wstrb (strb[0]), .data_sram_addr (addr[0]), .data_sram_wdata (wdata[0]),
        .data_sram_addr_ok (aok[0]), .data_sram_data_ok (dok[0]), .data_sram_rdata (rd[0]),
        .outstanding (outs[0])
    );

    data_sram_responder #(.ADDR_W(10), .QDEPTH(QD), .RESP_LAT(LAT_B)) u_dut_b (
        .clk (clk), .resetn (resetn),
        .data_sram_req (req[1]), .data_sram_wr (wr[1]), .data_sram_size (sz[1]),
        .data_sram_wstrb (strb[1]), .data_sram_addr (addr[1]), .data_sram_wdata (wdata[1]),
        .data_sram_addr_ok (aok[1]), .data_sram_data_ok (dok[1]), .data_sram_rdata (rd[1]),
        .outstanding (outs[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s inst%0d: got %h want %h (cycle %0d)", nm, inst, act, exp, cyc);
    endtask

    // Reference model: responses due at max(accept+1+L, previous due+1+L), in order
    always @(negedge clk) begin
        int          lat;
        int          ix;
        int          due;
        logic        e_aok;
        logic        e_dok;
        logic [31:0] e_rd;
        logic        skip_rd;
        ent_t        ne;
        for (int i = 0; i < 2; i++) begin
            lat = (i == 0) ? LAT_A : LAT_B;
            if (!resetn) mq[i].delete();
            e_aok   = resetn && (mq[i].size() < QD);
            e_dok   = (mq[i].size() > 0) && (mq[i][0].due == cyc);
            e_rd    = 32'd0;
            skip_rd = 1'b0;
            if (e_dok && !mq[i][0].wr) begin
                e_rd    = mq[i][0].data;
                skip_rd = !mq[i][0].known;
            end
            chk("addr_ok", i, 32'(aok[i]), 32'(e_aok));
            chk("data_ok", i, 32'(dok[i]), 32'(e_dok));
            chk("outstanding", i, 32'(outs[i]), mq[i].size());
            if (!skip_rd) chk("rdata", i, rd[i], e_rd);
            if (dok[i]) rlog[i].push_back('{c: cyc, d: rd[i]});
            if (req[i] && e_aok) begin
                ix  = int'(addr[i][11:2]);
                due = cyc + 1 + lat;
                if (mq[i].size() > 0 && mq[i][mq[i].size()-1].due + 1 + lat > due)
                    due = mq[i][mq[i].size()-1].due + 1 + lat;
                ne.due   = due;
                ne.wr    = wr[i];
                ne.data  = wr[i] ? 32'd0 : mmem[i][ix];
                ne.known = wr[i] ? 1'b1 : (mk[i][ix] == 4'hF);
                if (wr[i]) begin
                    for (int b = 0; b < 4; b++) begin
                        if (strb[i][b]) begin
                            mmem[i][ix][8*b +: 8] = wdata[i][8*b +: 8];
                            mk[i][ix][b] = 1'b1;
                        end
                    end
                end
                mq[i].push_back(ne);
            end
            if (e_dok) void'(mq[i].pop_front());
        end
    end

    task automatic idle(input int n);
        req[0] = 1'b0;
        req[1] = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present a word request on instance i and hold it until accepted
    task automatic issue(input int i, input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, output int acc);
        bit got;
        got = 1'b0;
        acc = -1;
        req[i] = 1'b1; wr[i] = w; addr[i] = a; wdata[i] = d; strb[i] = s; sz[i] = SZ_W;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (aok[i]) begin got = 1'b1; acc = cyc; end
            @(posedge clk);
            #1;
            if (got) break;
        end
        req[i] = 1'b0;
        if (!got) chk("issue_timeout", i, 32'(got), 32'd1);
    endtask

    initial begin
        int a0, a1;
        int acc [5];
        logic [31:0] r;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 1024; j++) begin mk[i][j] = 4'h0; mmem[i][j] = 32'd0; end
            req[i] = 0; wr[i] = 0; sz[i] = SZ_W; strb[i] = 0; addr[i] = 0; wdata[i] = 0;
        end
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;

        // Idle after reset
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("idle_addr_ok", i, 32'(aok[i]), 32'd1);
            chk("idle_data_ok", i, 32'(dok[i]), 32'd0);
            chk("idle_outstanding", i, 32'(outs[i]), 32'd0);
            chk("idle_rdata", i, rd[i], 32'd0);
        end
        @(posedge clk); #1;

        // Write then read, latency 1
        rlog[0].delete();
        issue(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, a0);
        issue(0, 1'b0, 32'h10, 32'h0, 4'h0, a1);
        idle(6);
        chk("rar_accept_gap", 0, a1 - a0, 32'd1);
        chk("wr_rd_nresp", 0, rlog[0].size(), 32'd2);
        if (rlog[0].size() >= 2) begin
            chk("wr_resp_cycle", 0, rlog[0][0].c, a0 + 2);
            chk("wr_resp_rdata", 0, rlog[0][0].d, 32'd0);
            chk("rd_resp_cycle", 0, rlog[0][1].c, a0 + 4);
            chk("rd_resp_rdata", 0, rlog[0][1].d, 32'hDEADBEEF);
        end

        // Byte strobes
        issue(0, 1'b1, 32'h20, 32'h11223344, 4'hF, a0);
        issue(0, 1'b1, 32'h20, 32'hAAAAAAAA, 4'b0100, a0);
        issue(0, 1'b0, 32'h20, 32'h0, 4'h0, a0);
        idle(6);
        chk("strobe_rdata", 0, rlog[0][rlog[0].size()-1].d, 32'h11AA3344);

        // Alias: 0x1000 wraps onto word 0
        issue(0, 1'b1, 32'h1000, 32'h5A5A5A5A, 4'hF, a0);
        issue(0, 1'b0, 32'h0000, 32'h0, 4'h0, a0);
        idle(6);
        chk("alias_rdata", 0, rlog[0][rlog[0].size()-1].d, 32'h5A5A5A5A);

        // Back-pressure on the latency-7 instance
        for (int k = 0; k < 5; k++) issue(1, 1'b1, 32'h100 + 4*k, 32'hB0000000 + k, 4'hF, a0);
        idle(60);
        rlog[1].delete();
        for (int k = 0; k < 4; k++) issue(1, 1'b0, 32'h100 + 4*k, 32'h0, 4'h0, acc[k]);
        @(negedge clk);
        chk("bp_full_outstanding", 1, 32'(outs[1]), 32'd4);
        chk("bp_full_addr_ok", 1, 32'(aok[1]), 32'd0);
        @(posedge clk); #1;
        issue(1, 1'b0, 32'h110, 32'h0, 4'h0, acc[4]);
        idle(60);
        chk("bp_accept1", 1, acc[1] - acc[0], 32'd1);
        chk("bp_accept3", 1, acc[3] - acc[0], 32'd3);
        chk("bp_accept5", 1, acc[4] - acc[0], 32'd9);
        chk("bp_nresp", 1, rlog[1].size(), 32'd5);
        if (rlog[1].size() == 5) begin
            chk("bp_first_cycle", 1, rlog[1][0].c, acc[0] + 8);
            chk("bp_last_cycle", 1, rlog[1][4].c, acc[0] + 40);
            for (int k = 0; k < 5; k++) chk("bp_order", 1, rlog[1][k].d, 32'hB0000000 + k);
        end

        // Asynchronous reset with reads outstanding
        for (int k = 0; k < 3; k++) issue(1, 1'b0, 32'h100 + 4*k, 32'h0, 4'h0, a0);
        chk("pre_rst_outstanding", 1, 32'(outs[1]), 32'd3);
        #2 resetn = 1'b0;
        #1;
        chk("rst_data_ok", 1, 32'(dok[1]), 32'd0);
        chk("rst_outstanding", 1, 32'(outs[1]), 32'd0);
        chk("rst_addr_ok", 1, 32'(aok[1]), 32'd0);
        rlog[1].delete();
        @(posedge clk);
        #1 resetn = 1'b1;
        idle(40);
        chk("post_rst_no_resp", 1, rlog[1].size(), 32'd0);
        issue(1, 1'b0, 32'h104, 32'h0, 4'h0, a0);
        idle(12);
        chk("post_rst_array", 1, rlog[1][rlog[1].size()-1].d, 32'hB0000001);

        // Random traffic on both instances
        for (int t = 0; t < 1500; t++) begin
            for (int i = 0; i < 2; i++) begin
                r        = $urandom();
                req[i]   = ($urandom_range(0, 99) < 60);
                wr[i]    = 1'($urandom_range(0, 1));
                sz[i]    = 2'($urandom_range(0, 2));
                strb[i]  = 4'($urandom_range(0, 15));
                wdata[i] = $urandom();
                addr[i]  = {r[31:12], 6'd0, 4'($urandom_range(0, 15)), r[1:0]};
            end
            @(posedge clk); #1;
        end
        idle(100);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
